// File: rtl/maze_carver.sv
// Maze carve engine: randomised depth-first backtracker over a MAZE_W x MAZE_H
// wall store, with a registered wall read port for display and movement logic.
module maze_carver #(
    parameter int          MAZE_W    = 16,
    parameter int          MAZE_H    = 12,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       carve,
    output logic       finished_carve,
    output logic       busy,
    input  logic [3:0] rd_col,
    input  logic [3:0] rd_row,
    output logic       rd_wall_e,
    output logic       rd_wall_s
);

    localparam int N     = MAZE_W * MAZE_H;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_PICK, S_STEP, S_POP, S_DONE} state_t;

    function automatic idx_t cell_idx(input logic [3:0] col, input logic [3:0] row);
        return idx_t'(32'(row) * MAZE_W + 32'(col));
    endfunction

    state_t      state_r;
    logic        carve_q_r;
    logic [15:0] lfsr_r;
    logic [N-1:0] wall_e_r;
    logic [N-1:0] wall_s_r;
    logic [N-1:0] visited_r;
    logic [7:0]  stack_r [0:N-1];
    idx_t        sp_r;
    idx_t        init_cnt_r;
    logic [3:0]  cur_col_r;
    logic [3:0]  cur_row_r;
    logic [1:0]  dir_r;

    logic [3:0]  nb_col_s [4];
    logic [3:0]  nb_row_s [4];
    logic [3:0]  nb_ok_s;
    logic [3:0]  cand_s;
    logic        found_s;
    logic [1:0]  pick_dir_s;
    logic [1:0]  scan_dir_s;
    idx_t        cur_idx_s;
    idx_t        step_idx_s;
    idx_t        rd_idx_s;

    assign cur_idx_s  = cell_idx(cur_col_r, cur_row_r);
    assign step_idx_s = cell_idx(nb_col_s[dir_r], nb_row_s[dir_r]);
    assign rd_idx_s   = cell_idx(rd_col, rd_row);

    // Neighbours of the current cell in N/E/S/W order and which are unvisited
    always_comb begin
        nb_col_s[0] = cur_col_r;        nb_row_s[0] = cur_row_r - 4'd1;
        nb_col_s[1] = cur_col_r + 4'd1; nb_row_s[1] = cur_row_r;
        nb_col_s[2] = cur_col_r;        nb_row_s[2] = cur_row_r + 4'd1;
        nb_col_s[3] = cur_col_r - 4'd1; nb_row_s[3] = cur_row_r;
        nb_ok_s[0]  = (cur_row_r != 4'd0);
        nb_ok_s[1]  = (cur_col_r != 4'(MAZE_W - 1));
        nb_ok_s[2]  = (cur_row_r != 4'(MAZE_H - 1));
        nb_ok_s[3]  = (cur_col_r != 4'd0);
        cand_s      = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (nb_ok_s[k]) begin
                cand_s[k] = ~visited_r[cell_idx(nb_col_s[k], nb_row_s[k])];
            end else begin
                cand_s[k] = 1'b0;
            end
        end
    end

    // Clockwise scan from the random start direction; first candidate wins
    always_comb begin
        found_s    = 1'b0;
        pick_dir_s = lfsr_r[1:0];
        scan_dir_s = lfsr_r[1:0];
        for (int k = 0; k < 4; k++) begin
            scan_dir_s = lfsr_r[1:0] + 2'(k);
            if (!found_s && cand_s[scan_dir_s]) begin
                found_s    = 1'b1;
                pick_dir_s = scan_dir_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11; never reseeded between mazes
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    // Carve FSM with wall store, visited map and backtrack stack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            carve_q_r      <= 1'b0;
            finished_carve <= 1'b0;
            busy           <= 1'b0;
            wall_e_r       <= '1;
            wall_s_r       <= '1;
            visited_r      <= '0;
            sp_r           <= idx_t'(0);
            init_cnt_r     <= idx_t'(0);
            cur_col_r      <= 4'd0;
            cur_row_r      <= 4'd0;
            dir_r          <= 2'd0;
            for (int i = 0; i < N; i++) begin
                stack_r[i] <= 8'd0;
            end
        end else begin
            carve_q_r <= carve;
            case (state_r)
                S_IDLE: begin
                    finished_carve <= 1'b0;
                    if (carve && !carve_q_r) begin
                        state_r    <= S_INIT;
                        init_cnt_r <= idx_t'(0);
                        busy       <= 1'b1;
                    end else begin
                        busy       <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (!carve) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        wall_e_r[init_cnt_r]  <= 1'b1;
                        wall_s_r[init_cnt_r]  <= 1'b1;
                        visited_r[init_cnt_r] <= 1'b0;
                        if (init_cnt_r == idx_t'(N - 1)) begin
                            // Later assignment wins, so (0,0) ends up visited even when N=1
                            visited_r[0] <= 1'b1;
                            cur_col_r    <= 4'd0;
                            cur_row_r    <= 4'd0;
                            sp_r         <= idx_t'(0);
                            state_r      <= S_PICK;
                        end else begin
                            init_cnt_r   <= init_cnt_r + idx_t'(1);
                        end
                    end
                end
                S_PICK: begin
                    if (!carve) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (found_s) begin
                        dir_r   <= pick_dir_s;
                        state_r <= S_STEP;
                    end else if (sp_r == idx_t'(0)) begin
                        state_r        <= S_DONE;
                        busy           <= 1'b0;
                        finished_carve <= 1'b1;
                    end else begin
                        state_r <= S_POP;
                    end
                end
                S_STEP: begin
                    if (!carve) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        stack_r[sp_r] <= {cur_row_r, cur_col_r};
                        sp_r          <= sp_r + idx_t'(1);
                        case (dir_r)
                            2'd0:    wall_s_r[step_idx_s] <= 1'b0;
                            2'd1:    wall_e_r[cur_idx_s]  <= 1'b0;
                            2'd2:    wall_s_r[cur_idx_s]  <= 1'b0;
                            2'd3:    wall_e_r[step_idx_s] <= 1'b0;
                            default: wall_e_r[cur_idx_s]  <= wall_e_r[cur_idx_s];
                        endcase
                        visited_r[step_idx_s] <= 1'b1;
                        cur_col_r <= nb_col_s[dir_r];
                        cur_row_r <= nb_row_s[dir_r];
                        state_r   <= S_PICK;
                    end
                end
                S_POP: begin
                    if (!carve) begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        {cur_row_r, cur_col_r} <= stack_r[sp_r - idx_t'(1)];
                        sp_r    <= sp_r - idx_t'(1);
                        state_r <= S_PICK;
                    end
                end
                S_DONE: begin
                    if (!carve) begin
                        state_r        <= S_IDLE;
                        finished_carve <= 1'b0;
                    end else begin
                        finished_carve <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= S_IDLE;
                    finished_carve <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; off-grid addresses read as closed walls
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wall_e <= 1'b1;
            rd_wall_s <= 1'b1;
        end else if ((32'(rd_col) >= MAZE_W) || (32'(rd_row) >= MAZE_H)) begin
            rd_wall_e <= 1'b1;
            rd_wall_s <= 1'b1;
        end else begin
            rd_wall_e <= wall_e_r[rd_idx_s];
            rd_wall_s <= wall_s_r[rd_idx_s];
        end
    end

endmodule

// File: tb/tb_maze_carver.sv
// Directed bench for maze_carver: a 4x4 instance for maze shape, tree property,
// restart and abort behaviour, plus a 1x1 instance for the degenerate case.
module tb_maze_carver;

    logic       clk = 1'b0;
    logic       reset;
    logic       carve;
    logic       carve1;
    logic       fin, busy, rd_e, rd_s;
    logic       fin1, busy1, rd_e1, rd_s1;
    logic [3:0] rd_col, rd_row, rd_col1, rd_row1;

    int errors = 0;
    int checks = 0;

    bit me [4][4];
    bit ms [4][4];
    bit prev_e [4][4];
    bit prev_s [4][4];

    localparam int LAT_4X4 = 16 + 4 * 15 + 3;
    localparam int LAT_1X1 = 1 + 0 + 3;

    always #5 clk = ~clk;

    maze_carver #(.MAZE_W(4), .MAZE_H(4), .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .reset(reset), .carve(carve), .finished_carve(fin), .busy(busy),
        .rd_col(rd_col), .rd_row(rd_row), .rd_wall_e(rd_e), .rd_wall_s(rd_s)
    );

    maze_carver #(.MAZE_W(1), .MAZE_H(1), .LFSR_SEED(16'hACE1)) u_dut1 (
        .clk(clk), .reset(reset), .carve(carve1), .finished_carve(fin1), .busy(busy1),
        .rd_col(rd_col1), .rd_row(rd_row1), .rd_wall_e(rd_e1), .rd_wall_s(rd_s1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_maze();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rd_col = 4'(c);
                rd_row = 4'(r);
                tick();
                me[c][r] = rd_e;
                ms[c][r] = rd_s;
            end
        end
    endtask

    function automatic int count_cleared();
        int n = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (c < 3 && !me[c][r]) n++;
                if (r < 3 && !ms[c][r]) n++;
            end
        end
        return n;
    endfunction

    function automatic int count_boundary_open();
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!me[3][i]) n++;
            if (!ms[i][3]) n++;
        end
        return n;
    endfunction

    function automatic int flood_count(output int tree_edges);
        bit reach [4][4];
        int n = 0;
        tree_edges = 0;
        reach = '{default: 1'b0};
        reach[0][0] = 1'b1;
        repeat (16) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (reach[c][r]) begin
                        if (c < 3 && !me[c][r] && !reach[c+1][r]) begin reach[c+1][r] = 1'b1; tree_edges++; end
                        if (r < 3 && !ms[c][r] && !reach[c][r+1]) begin reach[c][r+1] = 1'b1; tree_edges++; end
                        if (c > 0 && !me[c-1][r] && !reach[c-1][r]) begin reach[c-1][r] = 1'b1; tree_edges++; end
                        if (r > 0 && !ms[c][r-1] && !reach[c][r-1]) begin reach[c][r-1] = 1'b1; tree_edges++; end
                    end
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (reach[c][r]) n++;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1; carve = 1'b0; carve1 = 1'b0;
        rd_col = 4'd0; rd_row = 4'd0; rd_col1 = 4'd0; rd_row1 = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({fin, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_status got fin,busy=%b%b want 00", fin, busy);
        end
        checks++;
        if ({fin1, busy1, rd_e1, rd_s1} !== 4'b0011) begin
            errors++; $display("FAIL reset_1x1 got %b want 0011", {fin1, busy1, rd_e1, rd_s1});
        end
        read_maze();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if ({me[c][r], ms[c][r]} !== 2'b11) begin
                    errors++; $display("FAIL reset_walls (%0d,%0d) got %b%b want 11", c, r, me[c][r], ms[c][r]);
                end
            end
        end
    endtask

    task automatic test_carve();
        int cyc;
        carve = 1'b1;
        tick();
        cyc = 1;
        checks++;
        if ({busy, fin} !== 2'b10) begin
            errors++; $display("FAIL carve_busy got busy,fin=%b%b want 10", busy, fin);
        end
        while (!fin && cyc < LAT_4X4) begin
            tick();
            cyc++;
        end
        checks++;
        if (fin !== 1'b1) begin
            errors++; $display("FAIL carve_done got fin=%b after %0d cycles want 1", fin, cyc);
        end
        read_maze();
        checks++;
        if (count_cleared() !== 15) begin
            errors++; $display("FAIL carve_cleared got %0d want 15", count_cleared());
        end
        checks++;
        if (count_boundary_open() !== 0) begin
            errors++; $display("FAIL carve_boundary got %0d open want 0", count_boundary_open());
        end
        checks++;
        if ({busy, fin} !== 2'b01) begin
            errors++; $display("FAIL carve_hold got busy,fin=%b%b want 01", busy, fin);
        end
        prev_e = me;
        prev_s = ms;
    endtask

    task automatic test_flood();
        int reached, edges;
        reached = flood_count(edges);
        checks++;
        if (reached !== 16) begin
            errors++; $display("FAIL flood_reach got %0d want 16", reached);
        end
        checks++;
        if (edges !== count_cleared()) begin
            errors++; $display("FAIL flood_tree used %0d openings, %0d cleared", edges, count_cleared());
        end
    endtask

    task automatic test_rerun();
        int cyc, diff;
        carve = 1'b0;
        tick();
        checks++;
        if ({busy, fin} !== 2'b00) begin
            errors++; $display("FAIL drop_carve got busy,fin=%b%b want 00", busy, fin);
        end
        carve = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cyc++;
            checks++;
            if ({busy, fin} !== 2'b10) begin
                errors++; $display("FAIL rerun_init cycle %0d got busy,fin=%b%b want 10", i, busy, fin);
            end
        end
        while (!fin && cyc < LAT_4X4) begin
            tick();
            cyc++;
        end
        checks++;
        if (fin !== 1'b1) begin
            errors++; $display("FAIL rerun_done got fin=%b after %0d cycles want 1", fin, cyc);
        end
        read_maze();
        diff = 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (me[c][r] != prev_e[c][r] || ms[c][r] != prev_s[c][r]) diff++;
            end
        end
        checks++;
        if (diff == 0) begin
            errors++; $display("FAIL rerun_differs got %0d differing cells want >0", diff);
        end
        checks++;
        if (count_cleared() !== 15) begin
            errors++; $display("FAIL rerun_cleared got %0d want 15", count_cleared());
        end
    endtask

    task automatic test_reset_abort();
        int cyc, reached, edges;
        carve = 1'b0;
        tick();
        carve = 1'b1;
        repeat (30) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre got busy=%b want 1", busy);
        end
        reset = 1'b1;
        carve = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, fin} !== 2'b00) begin
            errors++; $display("FAIL abort_status got busy,fin=%b%b want 00", busy, fin);
        end
        read_maze();
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if ({me[c][r], ms[c][r]} !== 2'b11) begin
                    errors++; $display("FAIL abort_walls (%0d,%0d) got %b%b want 11", c, r, me[c][r], ms[c][r]);
                end
            end
        end
        carve = 1'b1;
        cyc = 0;
        while (!fin && cyc < LAT_4X4) begin
            tick();
            cyc++;
        end
        checks++;
        if (fin !== 1'b1) begin
            errors++; $display("FAIL abort_recarve got fin=%b after %0d cycles want 1", fin, cyc);
        end
        read_maze();
        reached = flood_count(edges);
        checks++;
        if ({count_cleared(), reached} !== {32'sd15, 32'sd16}) begin
            errors++; $display("FAIL abort_maze got cleared=%0d reached=%0d want 15,16", count_cleared(), reached);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] cols [4];
        logic [3:0] rows [4];
        cols = '{4'd4, 4'd0, 4'd4, 4'd15};
        rows = '{4'd0, 4'd4, 4'd4, 4'd15};
        for (int i = 0; i < 4; i++) begin
            rd_col = cols[i];
            rd_row = rows[i];
            tick();
            checks++;
            if ({rd_e, rd_s} !== 2'b11) begin
                errors++; $display("FAIL oob (%0d,%0d) got %b%b want 11", cols[i], rows[i], rd_e, rd_s);
            end
        end
    endtask

    task automatic test_single_cell();
        int cyc;
        carve1 = 1'b1;
        cyc = 0;
        while (!fin1 && cyc < LAT_1X1) begin
            tick();
            cyc++;
        end
        checks++;
        if (fin1 !== 1'b1) begin
            errors++; $display("FAIL single_done got fin=%b after %0d cycles want 1", fin1, cyc);
        end
        rd_col1 = 4'd0;
        rd_row1 = 4'd0;
        tick();
        checks++;
        if ({rd_e1, rd_s1, busy1} !== 3'b110) begin
            errors++; $display("FAIL single_walls got e,s,busy=%b want 110", {rd_e1, rd_s1, busy1});
        end
        rd_col1 = 4'd1;
        tick();
        checks++;
        if ({rd_e1, rd_s1} !== 2'b11) begin
            errors++; $display("FAIL single_oob got %b%b want 11", rd_e1, rd_s1);
        end
    endtask

    initial begin
        test_reset();
        test_carve();
        test_flood();
        test_out_of_range();
        test_rerun();
        test_reset_abort();
        test_single_cell();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
